// File: rtl/axis_fifo_wr_ctrl.sv
// Packs AXI-Stream beats into FIFO words behind a 2-entry skid buffer so tready stays registered.
// Define AXIS_FIFO_WR_CTRL_PKT_LIMIT_EN to cut packets longer than MAX_BEATS by forcing tlast.

module axis_fifo_wr_ctrl #(
  parameter int BUS_WIDTH  = 1,
  parameter int FIFO_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int MAX_BEATS  = 256
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_arst,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [BUS_WIDTH*8-1:0]    s_axis_tdata,
  input  logic [BUS_WIDTH-1:0]      s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
  output logic                      wr_en,
  output logic [FIFO_WIDTH*8-1:0]   wr_data,
  input  logic                      wr_full,
  output logic                      wr_tlast,
  output logic                      pkt_cut
);

  localparam int WORD_W = FIFO_WIDTH * 8;
  localparam int PACK_W = DEST_WIDTH + USER_WIDTH + BUS_WIDTH * 9 + 1;

  if (PACK_W > WORD_W) begin : g_pack_too_wide
    $error("axis_fifo_wr_ctrl: packed width %0d exceeds FIFO word width %0d", PACK_W, WORD_W);
  end
  if (MAX_BEATS < 1) begin : g_bad_max_beats
    $error("axis_fifo_wr_ctrl: MAX_BEATS must be at least 1");
  end

  logic              ready_q;
  logic              out_valid, skid_valid;
  logic              out_valid_next, skid_valid_next;
  logic [WORD_W-1:0] out_data, skid_data, in_word;
  logic              accept, null_beat, load, drain;
  logic              load_out, load_skid, skid_to_out;
  logic              cut_now, tlast_eff;

  assign null_beat = (s_axis_tkeep == '0) & ~s_axis_tlast;
  assign accept    = s_axis_tvalid & ready_q;
  assign load      = accept & ~null_beat;
  assign drain     = out_valid & ~wr_full;
  assign tlast_eff = s_axis_tlast | cut_now;
  assign in_word   = WORD_W'({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tdest, tlast_eff});

  // tready is low whenever SKID holds a beat, so a load never collides with a SKID->OUT move.
  always_comb begin
    skid_to_out     = drain & skid_valid;
    load_out        = load & (~out_valid | (drain & ~skid_valid));
    load_skid       = load & out_valid & ~drain;
    out_valid_next  = load_out | skid_to_out | (out_valid & ~drain);
    skid_valid_next = load_skid | (skid_valid & ~skid_to_out);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      ready_q    <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else begin
      ready_q    <= ~skid_valid_next;
      out_valid  <= out_valid_next;
      skid_valid <= skid_valid_next;
      if (load_out)
        out_data <= in_word;
      else if (skid_to_out)
        out_data <= skid_data;
      if (load_skid)
        skid_data <= in_word;
    end
  end

`ifdef AXIS_FIFO_WR_CTRL_PKT_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  logic [CNT_W-1:0] beat_cnt;
  logic             out_cut, skid_cut;

  assign cut_now = (beat_cnt == CNT_W'(MAX_BEATS - 1)) & ~s_axis_tlast;
  assign pkt_cut = wr_en & out_cut;

  // Counted as beats enter the buffer; every buffered beat is written in order, so this
  // tracks the written-beat count of the packet while letting the cut be decided at load.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      beat_cnt <= '0;
      out_cut  <= 1'b0;
      skid_cut <= 1'b0;
    end else begin
      if (load)
        beat_cnt <= tlast_eff ? '0 : beat_cnt + 1'b1;
      if (load_out)
        out_cut <= cut_now;
      else if (skid_to_out)
        out_cut <= skid_cut;
      if (load_skid)
        skid_cut <= cut_now;
    end
  end
`else
  assign cut_now = 1'b0;
  assign pkt_cut = 1'b0;
`endif

  assign s_axis_tready = ready_q;
  assign wr_en         = drain;
  assign wr_data       = out_data;
  assign wr_tlast      = wr_en & out_data[0];

endmodule
